mgmt_storage_arbiter: RTL and testbench

MGMT_STORAGE_ARBITER -- requirements
Module: mgmt_storage_arbiter

---
 rtl/mgmt_storage_arbiter.sv | 94 +++++++++
 tb/tb_mgmt_storage_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mgmt_storage_arbiter.sv
// mgmt_storage_arbiter: two-requester arbiter (management R/W, housekeeping RO) onto banked RAM
module mgmt_storage_arbiter #(
    parameter int N_BANKS     = 2,
    parameter int ADDR_W      = 8,
    parameter int HK_MAX_WAIT = 4,
    localparam int BANK_W     = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
    localparam int AW         = BANK_W + ADDR_W
) (
    input  logic                  core_clk,
    input  logic                  core_rst,
    input  logic                  m_req,
    input  logic                  m_we,
    input  logic [3:0]            m_sel,
    input  logic [AW-1:0]         m_addr,
    input  logic [31:0]           m_wdata,
    output logic                  m_gnt,
    output logic                  m_rvalid,
    output logic [31:0]           m_rdata,
    output logic                  m_err,
    input  logic                  h_req,
    input  logic [AW-1:0]         h_addr,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [31:0]           h_rdata,
    output logic                  h_err,
    output logic [N_BANKS-1:0]    ram_ena,
    output logic [N_BANKS-1:0]    ram_wen,
    output logic [4*N_BANKS-1:0]  ram_wen_mask,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [32*N_BANKS-1:0] ram_rdata
);
    localparam logic [BANK_W:0] NB  = N_BANKS[BANK_W:0];
    localparam logic [3:0]      HMW = 4'(HK_MAX_WAIT);
    logic [3:0]        hk_wait_q, hk_wait_d;
    logic              m_v_q, m_v_d, h_v_q, h_v_d, rd_q, rd_d, err_q, err_d;
    logic [BANK_W-1:0] bank_q, bank_d, bank;
    logic              h_win, any_gnt, in_rng;
    logic [AW-1:0]     sel_addr;
    logic [31:0]       lane;
    // grant selection, shared address decode and next-state for the response pipeline
    always_comb begin
        h_win     = h_req && (!m_req || hk_wait_q >= HMW);
        h_gnt     = !core_rst && h_win;
        m_gnt     = !core_rst && m_req && !h_win;
        any_gnt   = m_gnt || h_gnt;
        sel_addr  = h_gnt ? h_addr : m_addr;
        bank      = sel_addr[AW-1 -: BANK_W];
        in_rng    = {1'b0, bank} < NB;
        ram_addr  = any_gnt ? sel_addr[ADDR_W-1:0] : '0;
        ram_wdata = (m_gnt && m_we) ? m_wdata : '0;
        hk_wait_d = (h_req && !h_gnt) ? ((hk_wait_q == 4'hF) ? 4'hF : hk_wait_q + 4'h1) : 4'h0;
        m_v_d     = m_gnt;
        h_v_d     = h_gnt;
        rd_d      = h_gnt || !m_we;
        err_d     = any_gnt && !in_rng;
        bank_d    = bank;
    end
    for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
        assign ram_ena[g]            = any_gnt && in_rng && bank == BANK_W'(g);
        assign ram_wen[g]            = ram_ena[g] && m_gnt && m_we;
        assign ram_wen_mask[4*g +: 4] = ram_wen[g] ? m_sel : 4'h0;
    end
    // pick the read lane of the bank that was accessed last cycle
    always_comb begin
        lane = '0;
        for (int i = 0; i < N_BANKS; i++)
            if (bank_q == BANK_W'(i)) lane = ram_rdata[32*i +: 32];
    end
    assign m_rvalid = !core_rst && m_v_q;
    assign h_rvalid = !core_rst && h_v_q;
    assign m_err    = m_rvalid && err_q;
    assign h_err    = h_rvalid && err_q;
    assign m_rdata  = (m_rvalid && rd_q && !err_q) ? lane : '0;
    assign h_rdata  = (h_rvalid && rd_q && !err_q) ? lane : '0;
    // starvation counter and one-cycle response pipeline, flushed by reset
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            hk_wait_q <= '0;
            m_v_q     <= 1'b0;
            h_v_q     <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
            bank_q    <= '0;
        end else begin
            hk_wait_q <= hk_wait_d;
            m_v_q     <= m_v_d;
            h_v_q     <= h_v_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            bank_q    <= bank_d;
        end
    end
endmodule

// File: tb/tb_mgmt_storage_arbiter.sv
// tb_mgmt_storage_arbiter: directed checks of arbitration, banking, responses and reset
module tb_mgmt_storage_arbiter;
    localparam int NB = 3;
    localparam int AWD = 8;
    localparam int AW = 10;
    localparam logic [31:0] L0 = 32'hA0A0_0000;
    localparam logic [31:0] L1 = 32'hB1B1_1111;
    localparam logic [31:0] L2 = 32'hC2C2_2222;
    logic core_clk = 0, core_rst = 1;
    logic m_req = 0, m_we = 0, h_req = 0;
    logic [3:0] m_sel = 0;
    logic [AW-1:0] m_addr = 0, h_addr = 0;
    logic [31:0] m_wdata = 0;
    logic m_gnt, m_rvalid, m_err, h_gnt, h_rvalid, h_err;
    logic [31:0] m_rdata, h_rdata, ram_wdata;
    logic [NB-1:0] ram_ena, ram_wen;
    logic [4*NB-1:0] ram_wen_mask;
    logic [AWD-1:0] ram_addr;
    logic [32*NB-1:0] ram_rdata;
    int checks = 0, failures = 0;
    assign ram_rdata = {L2, L1, L0};
    always #5 core_clk = ~core_clk;
    mgmt_storage_arbiter #(.N_BANKS(NB), .ADDR_W(AWD), .HK_MAX_WAIT(4)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .m_req(m_req), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
        .h_req(h_req), .h_addr(h_addr),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_err(h_err),
        .ram_ena(ram_ena), .ram_wen(ram_wen), .ram_wen_mask(ram_wen_mask),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic test_reset();
        core_rst = 1; m_req = 1; h_req = 1; m_addr = 10'h001; h_addr = 10'h101;
        step(); step(); #1;
        checks++; if (m_gnt !== 1'b0) begin failures++; $display("FAIL rst_m_gnt got=%b exp=0", m_gnt); end
        checks++; if (h_gnt !== 1'b0) begin failures++; $display("FAIL rst_h_gnt got=%b exp=0", h_gnt); end
        checks++; if (ram_ena !== 3'b000) begin failures++; $display("FAIL rst_ram_ena got=%b exp=000", ram_ena); end
        checks++; if (m_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b%b exp=00", m_rvalid, h_rvalid); end
        step(); core_rst = 0; m_req = 0; h_req = 0;
    endtask

    task automatic test_write_read();
        step(); m_req = 1; m_we = 1; m_sel = 4'b0011; m_addr = 10'h005; m_wdata = 32'hDEADBEEF; #1;
        checks++; if (m_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b exp=1", m_gnt); end
        checks++; if (ram_ena !== 3'b001 || ram_wen !== 3'b001) begin failures++; $display("FAIL wr_ena_wen got=%b/%b exp=001/001", ram_ena, ram_wen); end
        checks++; if (ram_wen_mask !== 12'h003) begin failures++; $display("FAIL wr_mask got=%h exp=003", ram_wen_mask); end
        checks++; if (ram_addr !== 8'h05 || ram_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_addr_data got=%h/%h exp=05/deadbeef", ram_addr, ram_wdata); end
        step(); m_we = 0; m_sel = 4'b1111; #1;
        checks++; if (m_rvalid !== 1'b1 || m_rdata !== 32'h0 || m_err !== 1'b0) begin failures++; $display("FAIL wr_resp got=%b/%h/%b exp=1/0/0", m_rvalid, m_rdata, m_err); end
        checks++; if (ram_ena !== 3'b001 || ram_wen !== 3'b000 || ram_wen_mask !== 12'h000) begin failures++; $display("FAIL rd_ctrl got=%b/%b/%h exp=001/000/000", ram_ena, ram_wen, ram_wen_mask); end
        step(); m_req = 0; #1;
        checks++; if (m_rvalid !== 1'b1 || m_rdata !== L0) begin failures++; $display("FAIL rd_resp got=%b/%h exp=1/%h", m_rvalid, m_rdata, L0); end
        checks++; if (ram_addr !== 8'h00 || ram_wdata !== 32'h0 || m_gnt !== 1'b0) begin failures++; $display("FAIL idle_bus got=%h/%h/%b exp=00/0/0", ram_addr, ram_wdata, m_gnt); end
        step(); #1;
        checks++; if (m_rvalid !== 1'b0 || m_rdata !== 32'h0) begin failures++; $display("FAIL rd_done got=%b/%h exp=0/0", m_rvalid, m_rdata); end
    endtask

    task automatic test_hk_fairness();
        logic exp_h;
        for (int c = 0; c < 10; c++) begin
            step(); m_req = 1; m_we = 0; m_addr = 10'h003; h_req = 1; h_addr = 10'h107; #1;
            exp_h = (c == 4) || (c == 9);
            checks++; if (m_gnt !== !exp_h || h_gnt !== exp_h) begin failures++; $display("FAIL fair_c%0d got=m%b h%b exp=m%b h%b", c, m_gnt, h_gnt, !exp_h, exp_h); end
            checks++; if (h_rvalid !== (c == 5)) begin failures++; $display("FAIL fair_hrv_c%0d got=%b exp=%b", c, h_rvalid, c == 5); end
            if (c == 5) begin
                checks++; if (h_rdata !== L1) begin failures++; $display("FAIL fair_hrdata got=%h exp=%h", h_rdata, L1); end
            end
        end
        step(); m_req = 0; h_req = 0;
    endtask

    task automatic test_out_of_range();
        step(); h_req = 1; h_addr = 10'h310; #1;
        checks++; if (h_gnt !== 1'b1 || ram_ena !== 3'b000) begin failures++; $display("FAIL oor_gnt got=%b/%b exp=1/000", h_gnt, ram_ena); end
        step(); h_req = 0; #1;
        checks++; if (h_rvalid !== 1'b1 || h_err !== 1'b1 || h_rdata !== 32'h0) begin failures++; $display("FAIL oor_resp got=%b/%b/%h exp=1/1/0", h_rvalid, h_err, h_rdata); end
        checks++; if (m_err !== 1'b0 || m_rvalid !== 1'b0) begin failures++; $display("FAIL oor_m got=%b/%b exp=0/0", m_err, m_rvalid); end
        step(); #1;
        checks++; if (h_rvalid !== 1'b0 || h_err !== 1'b0) begin failures++; $display("FAIL oor_done got=%b/%b exp=0/0", h_rvalid, h_err); end
    endtask

    task automatic test_reset_flush();
        step(); m_req = 1; m_we = 0; m_addr = 10'h122; #1;
        checks++; if (m_gnt !== 1'b1 || ram_ena !== 3'b010) begin failures++; $display("FAIL fl_gnt got=%b/%b exp=1/010", m_gnt, ram_ena); end
        step(); core_rst = 1; m_req = 0; h_req = 1; h_addr = 10'h201; #1;
        checks++; if (m_rvalid !== 1'b0 || h_gnt !== 1'b0 || ram_ena !== 3'b000) begin failures++; $display("FAIL fl_rst got=%b/%b/%b exp=0/0/000", m_rvalid, h_gnt, ram_ena); end
        step(); core_rst = 0; #1;
        checks++; if (h_gnt !== 1'b1 || ram_ena !== 3'b100 || m_rvalid !== 1'b0) begin failures++; $display("FAIL fl_post got=%b/%b/%b exp=1/100/0", h_gnt, ram_ena, m_rvalid); end
        step(); h_req = 0; #1;
        checks++; if (h_rvalid !== 1'b1 || h_rdata !== L2) begin failures++; $display("FAIL fl_resp got=%b/%h exp=1/%h", h_rvalid, h_rdata, L2); end
    endtask

    task automatic test_back_to_back();
        step(); m_req = 1; m_we = 0; m_addr = 10'h001; #1;
        checks++; if (m_gnt !== 1'b1 || ram_ena !== 3'b001) begin failures++; $display("FAIL b2b_g0 got=%b/%b exp=1/001", m_gnt, ram_ena); end
        step(); m_addr = 10'h102; #1;
        checks++; if (m_gnt !== 1'b1 || ram_ena !== 3'b010) begin failures++; $display("FAIL b2b_g1 got=%b/%b exp=1/010", m_gnt, ram_ena); end
        checks++; if (m_rvalid !== 1'b1 || m_rdata !== L0) begin failures++; $display("FAIL b2b_r0 got=%b/%h exp=1/%h", m_rvalid, m_rdata, L0); end
        step(); m_addr = 10'h203; #1;
        checks++; if (m_rvalid !== 1'b1 || m_rdata !== L1) begin failures++; $display("FAIL b2b_r1 got=%b/%h exp=1/%h", m_rvalid, m_rdata, L1); end
        step(); m_req = 0; h_req = 1; h_addr = 10'h004; #1;
        checks++; if (h_gnt !== 1'b1 || m_gnt !== 1'b0 || ram_ena !== 3'b001) begin failures++; $display("FAIL alt_hg got=%b/%b/%b exp=1/0/001", h_gnt, m_gnt, ram_ena); end
        checks++; if (m_rvalid !== 1'b1 || m_rdata !== L2) begin failures++; $display("FAIL alt_r2 got=%b/%h exp=1/%h", m_rvalid, m_rdata, L2); end
        step(); h_req = 0; #1;
        checks++; if (h_rvalid !== 1'b1 || h_rdata !== L0 || m_rvalid !== 1'b0) begin failures++; $display("FAIL alt_hr got=%b/%h/%b exp=1/%h/0", h_rvalid, h_rdata, m_rvalid, L0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hk_fairness();
        test_out_of_range();
        test_reset_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
